apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Two-requester APB master that shares the single 8-bit APB slave (`apb_slave`) between two on-chip command sources. It arbitrates round-robin and sequences the APB IDLE/SETUP/ACCESS phases. It waits on PREADY, returns PRDATA/PSLVERR to the granted requester, and aborts stalled transfers with a timeout error. It sits directly in front of `apb_slave` and is the only driver of its PSEL/PENABLE/PWRITE/PADDR/PWDATA.

Parameters:
- AW, 8, APB address width.
- DW, 8, APB data width.
- TIMEOUT, 16, max ACCESS-phase cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 command valid; held until accepted.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  AW  target address.
- req0_wdata  in  DW  write data (ignored for reads).
- req0_ready  out  1  command accepted this cycle.
- rsp0_valid  out  1  one-cycle completion pulse.
- rsp0_rdata  out  DW  read data; 0 for writes and timeouts.
- rsp0_err  out  1  PSLVERR or timeout; valid with rsp0_valid.
- req1_*/rsp1_*  same set as requester 0, for requester 1.
- PSEL, PENABLE, PWRITE  out  1  APB master controls.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB slave ready.
- PSLVERR  in  1  APB slave error.
- busy  out  1  high in SETUP or ACCESS.
- timeout_pulse  out  1  one-cycle pulse when a transfer is aborted.

Behaviour:
- Reset (RSTN=0, async): state=IDLE, all outputs 0, RR pointer favours requester 0, timeout counter 0. Reset mid-transfer drops PSEL/PENABLE immediately; the in-flight command is discarded with no rsp pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0.
  - If any req_valid, grant one requester. reqN_ready=1 combinationally (state==IDLE & grantN).
  - The command is latched into PWRITE/PADDR/PWDATA on that edge → SETUP.
  - No valid → stay in IDLE.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle → ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable for the whole phase.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR. Pulse rspN_valid next cycle with rdata/err → IDLE.
  - PREADY=0: stay in ACCESS and increment the counter.
  - Counter reaches TIMEOUT (TIMEOUT≠0): abort → IDLE, rsp err=1, rdata=0, timeout_pulse=1.
  - PREADY=1 on the same cycle the counter hits TIMEOUT: the PREADY completion wins.
- Every transfer returns through IDLE: at least one PSEL=0 cycle between transfers, never back-to-back SETUP.
- Latency with a zero-wait slave:
  - accept at edge T
  - SETUP during T..T+1
  - ACCESS during T+1..T+2 with PREADY=1
  - rsp_valid high T+2..T+3
  - earliest next accept at T+3
- Arbitration: round-robin.
  - Single requester valid → it is granted.
  - Both valid → the one the pointer favours is granted.
  - After a grant the pointer moves to favour the other requester.
  - The pointer updates only on an accepted grant.
- Requester rules: the requester must hold valid and its fields stable until ready. rsp has no backpressure. A new request may be raised in the same cycle rsp_valid pulses.
- PSLVERR is sampled only when PSEL&PENABLE&PREADY; it is ignored otherwise.
- PRDATA is registered into rsp rdata only for reads; writes return 0.
- Counter width: $clog2(TIMEOUT+1); it clears on entry to ACCESS.

Decomposition:
- Package apb_ctrl_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - default AW/DW localparams
  - the valid address range constants 8'h05..8'hF1, used by the bench
- Sub-module rr_arbiter2: inputs req[1:0] and accept; outputs one-hot gnt[1:0]; owns the priority pointer.

Test Plan:
- Zero-wait write: req0 write 0xCA←0x55 → PSEL high 2 cycles, PENABLE only the 2nd; rsp0_valid at T+2..T+3, err=0; slave mem[0xCA]=0x55.
- Fairness: req0 and req1 valid together after reset (0x37←0xAA, 0xB1←0x0F).
  - req0 is served first, then req1, with an IDLE cycle between.
  - Repeat simultaneous reqs → req1 is now served first.
- Wait states: read 0xCA with slave PREADY held low 3 cycles → ACCESS lasts 4 cycles, PADDR stable; rsp0_rdata=0x55, err=0.
- Slave error: write 0xFF and read 0x01 (out of range) → rsp err=1 for each. The following read of 0xB1 returns 0x0F, err=0.
- Timeout: PREADY stuck low, TIMEOUT=16.
  - After 16 ACCESS cycles: PSEL→0, timeout_pulse=1, rsp err=1, rdata=0.
  - The next request completes normally.
- Reset mid-ACCESS: drop RSTN between clock edges → PSEL/PENABLE go 0 asynchronously, no rsp pulse. After release, a pending req starts with a fresh SETUP and the RR pointer favours requester 0.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared FSM state type, default bus widths and the slave's decoded address window
// for the two-requester APB master.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_AW = 8;
  localparam int unsigned APB_DW = 8;

  // apb_slave answers PSLVERR outside this inclusive window
  localparam logic [7:0] ADDR_LO = 8'h05;
  localparam logic [7:0] ADDR_HI = 8'hF1;

  function automatic logic addr_in_range(input logic [7:0] addr);
    return (addr >= ADDR_LO) && (addr <= ADDR_HI);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant in the same cycle as the request.
// The priority pointer advances only on an accepted grant and then favours the other requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;  // 0 favours requester 0

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (accept && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: accept -> SETUP -> ACCESS (waits on PREADY) -> IDLE with a one-cycle rsp pulse.
// Requests are held off by ready outside IDLE; responses have no backpressure.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          RSTN,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR,
  output logic          busy,
  output logic          timeout_pulse
);

  localparam int unsigned   CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  apb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    rsp_vld_q, rsp_vld_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic          tmo_q, tmo_d;

  logic [1:0]    gnt;
  logic          accept;
  logic          done;
  logic          done_err;
  logic [DW-1:0] done_rdata;

  assign accept = (state_q == IDLE) && (gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk    (PCLK),
    .rst_n  (RSTN),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    cnt_d        = cnt_q;
    rsp_vld_d    = 2'b00;
    rsp_err_d    = rsp_err_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    tmo_d        = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          owner_d  = gnt[1];
          pwrite_d = gnt[1] ? req1_write : req0_write;
          paddr_d  = gnt[1] ? req1_addr  : req0_addr;
          pwdata_d = gnt[1] ? req1_wdata : req0_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the limit cycle is not aborted
        if (PREADY) begin
          state_d    = IDLE;
          done       = 1'b1;
          done_err   = PSLVERR;
          done_rdata = pwrite_q ? '0 : PRDATA;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
          state_d  = IDLE;
          done     = 1'b1;
          done_err = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      rsp_vld_d[owner_q] = 1'b1;
      rsp_err_d[owner_q] = done_err;
      if (owner_q) begin
        rsp1_rdata_d = done_rdata;
      end else begin
        rsp0_rdata_d = done_rdata;
      end
    end
  end

  always_ff @(posedge PCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      cnt_q        <= '0;
      rsp_vld_q    <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      cnt_q        <= cnt_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      tmo_q        <= tmo_d;
    end
  end

  assign req0_ready    = (state_q == IDLE) && gnt[0];
  assign req1_ready    = (state_q == IDLE) && gnt[1];
  assign rsp0_valid    = rsp_vld_q[0];
  assign rsp1_valid    = rsp_vld_q[1];
  assign rsp0_err      = rsp_err_q[0];
  assign rsp1_err      = rsp_err_q[1];
  assign rsp0_rdata    = rsp0_rdata_q;
  assign rsp1_rdata    = rsp1_rdata_q;
  assign PSEL          = (state_q != IDLE);
  assign PENABLE       = (state_q == ACCESS);
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter with a behavioural apb_slave (wait states, stuck PREADY, range errors)
// and a per-requester expected-response queue drained by a negedge monitor.
module tb_apb_master_arbiter;
  import apb_ctrl_pkg::*;

  localparam int TMO = 16;

  logic       PCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy, timeout_pulse;
  logic [7:0] PADDR, PWDATA, PRDATA;

  apb_master_arbiter #(.AW(8), .DW(8), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .RSTN(RSTN),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 PCLK = ~PCLK;

  // behavioural slave
  logic [7:0] mem [256];
  int         slv_wait  = 0;
  logic       slv_stuck = 1'b0;
  int         wcnt      = 0;
  logic       access_ph, in_rng;

  always_comb begin
    access_ph = PSEL && PENABLE;
    in_rng    = (PADDR >= ADDR_LO) && (PADDR <= ADDR_HI);
    PREADY    = access_ph && !slv_stuck && (wcnt >= slv_wait);
    PRDATA    = in_rng ? mem[PADDR] : 8'h00;
    PSLVERR   = PREADY && !in_rng;
  end

  always @(posedge PCLK) begin
    if (access_ph && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PREADY && PWRITE && in_rng) mem[PADDR] <= PWDATA;
  end

  // scoreboard
  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   passed = 0;
  int   total  = 0;
  logic prev_acc = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  int   acc_run = 0;
  int   last_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge PCLK) begin
    exp_t e;
    if (RSTN) begin
      if (rsp0_valid) begin
        if (q0.size() == 0) check("rsp0 unexpected pulse", 32'(rsp0_valid), 0);
        else begin
          e = q0.pop_front();
          check("rsp0 rdata", 32'(rsp0_rdata), 32'(e.rdata));
          check("rsp0 err", 32'(rsp0_err), 32'(e.err));
          check("rsp0 timeout_pulse", 32'(timeout_pulse), 32'(e.tmo));
          check("rsp0 PSEL low", 32'(PSEL), 0);
        end
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) check("rsp1 unexpected pulse", 32'(rsp1_valid), 0);
        else begin
          e = q1.pop_front();
          check("rsp1 rdata", 32'(rsp1_rdata), 32'(e.rdata));
          check("rsp1 err", 32'(rsp1_err), 32'(e.err));
          check("rsp1 timeout_pulse", 32'(timeout_pulse), 32'(e.tmo));
          check("rsp1 PSEL low", 32'(PSEL), 0);
        end
      end
      if (timeout_pulse && !rsp0_valid && !rsp1_valid)
        check("stray timeout_pulse", 32'(timeout_pulse), 0);
      if (prev_acc) check("no SETUP right after ACCESS", 32'(PSEL && !PENABLE), 0);
      if (prev_acc && PSEL && PENABLE) check("PADDR stable in ACCESS", 32'(PADDR), 32'(prev_addr));
    end
    if (PSEL && PENABLE) acc_run++;
    else if (acc_run != 0) begin
      last_len = acc_run;
      acc_run  = 0;
    end
    prev_acc  = PSEL && PENABLE;
    prev_addr = PADDR;
  end

  task automatic raise(input int n, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (n == 0) begin
      req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
    end else begin
      req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
    end
  endtask

  task automatic expect_rsp(input int n, input logic [7:0] rd, input logic er, input logic tm);
    exp_t e;
    e.rdata = rd; e.err = er; e.tmo = tm;
    if (n == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_accept(input int n);
    logic rdy;
    bit   ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        ok = 1'b1;
        grant_log.push_back(n);
        @(posedge PCLK);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
      end else begin
        @(negedge PCLK);
      end
    end
    check($sformatf("req%0d accepted within bound", n), 32'(ok), 1);
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      #2;
      ok = !busy && (q0.size() == 0) && (q1.size() == 0);
    end
    check("responses drained within bound", 32'(ok), 1);
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;

    repeat (2) @(negedge PCLK);
    check("reset PSEL", 32'(PSEL), 0);
    check("reset PENABLE", 32'(PENABLE), 0);
    check("reset busy", 32'(busy), 0);
    check("reset rsp0_valid", 32'(rsp0_valid), 0);
    check("reset rsp1_valid", 32'(rsp1_valid), 0);
    check("reset timeout_pulse", 32'(timeout_pulse), 0);
    check("reset PADDR", 32'(PADDR), 0);
    RSTN = 1'b1;
    @(negedge PCLK);

    // both requesters at once after reset: req0 first
    raise(0, 1'b1, 8'h37, 8'hAA); expect_rsp(0, 8'h00, 1'b0, 1'b0);
    raise(1, 1'b1, 8'hB1, 8'h0F); expect_rsp(1, 8'h00, 1'b0, 1'b0);
    #1;
    check("fair1 req0_ready", 32'(req0_ready), 1);
    check("fair1 req1_ready", 32'(req1_ready), 0);
    fork
      wait_accept(0);
      wait_accept(1);
    join
    wait_quiet();
    check("fair1 first grant", 32'(grant_log[0]), 0);
    check("fair1 second grant", 32'(grant_log[1]), 1);
    grant_log.delete();

    // zero-wait write with cycle-exact phase checks
    raise(0, 1'b1, 8'hCA, 8'h55); expect_rsp(0, 8'h00, 1'b0, 1'b0);
    #1;
    check("zw req0_ready", 32'(req0_ready), 1);
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    check("zw SETUP PSEL", 32'(PSEL), 1);
    check("zw SETUP PENABLE", 32'(PENABLE), 0);
    check("zw PADDR", 32'(PADDR), 'hCA);
    check("zw PWRITE", 32'(PWRITE), 1);
    check("zw PWDATA", 32'(PWDATA), 'h55);
    @(posedge PCLK); #1;
    check("zw ACCESS PSEL", 32'(PSEL), 1);
    check("zw ACCESS PENABLE", 32'(PENABLE), 1);
    @(posedge PCLK); #1;
    check("zw T+2 PSEL", 32'(PSEL), 0);
    check("zw T+2 rsp0_valid", 32'(rsp0_valid), 1);
    @(posedge PCLK); #1;
    check("zw T+3 rsp0_valid", 32'(rsp0_valid), 0);
    check("zw slave mem[CA]", 32'(mem[8'hCA]), 'h55);
    check("zw ACCESS length", 32'(last_len), 1);
    @(negedge PCLK);

    // last grant went to req0, so simultaneous requests now favour req1
    raise(0, 1'b0, 8'hB1, 8'h00); expect_rsp(0, 8'h0F, 1'b0, 1'b0);
    raise(1, 1'b0, 8'h37, 8'h00); expect_rsp(1, 8'hAA, 1'b0, 1'b0);
    #1;
    check("fair2 req1_ready", 32'(req1_ready), 1);
    check("fair2 req0_ready", 32'(req0_ready), 0);
    fork
      wait_accept(0);
      wait_accept(1);
    join
    wait_quiet();
    check("fair2 first grant", 32'(grant_log[0]), 1);
    check("fair2 second grant", 32'(grant_log[1]), 0);
    grant_log.delete();

    // three wait states
    slv_wait = 3;
    raise(0, 1'b0, 8'hCA, 8'h00); expect_rsp(0, 8'h55, 1'b0, 1'b0);
    wait_accept(0);
    wait_quiet();
    check("wait ACCESS length", 32'(last_len), 4);

    // PREADY on the last allowed cycle completes normally
    slv_wait = TMO - 1;
    raise(1, 1'b0, 8'hCA, 8'h00); expect_rsp(1, 8'h55, 1'b0, 1'b0);
    wait_accept(1);
    wait_quiet();
    check("edge ACCESS length", 32'(last_len), TMO);
    slv_wait = 0;

    // slave errors, then a good read
    raise(0, 1'b1, 8'hFF, 8'h12); expect_rsp(0, 8'h00, 1'b1, 1'b0);
    wait_accept(0);
    wait_quiet();
    raise(1, 1'b0, 8'h01, 8'h00); expect_rsp(1, 8'h00, 1'b1, 1'b0);
    wait_accept(1);
    wait_quiet();
    raise(0, 1'b0, 8'hB1, 8'h00); expect_rsp(0, 8'h0F, 1'b0, 1'b0);
    wait_accept(0);
    wait_quiet();

    // stuck slave -> timeout, then recovery
    slv_stuck = 1'b1;
    raise(1, 1'b0, 8'h40, 8'h00); expect_rsp(1, 8'h00, 1'b1, 1'b1);
    wait_accept(1);
    wait_quiet();
    check("timeout ACCESS length", 32'(last_len), TMO);
    slv_stuck = 1'b0;
    raise(1, 1'b1, 8'h40, 8'h99); expect_rsp(1, 8'h00, 1'b0, 1'b0);
    wait_accept(1);
    wait_quiet();
    check("post-timeout mem[40]", 32'(mem[8'h40]), 'h99);

    // async reset in the middle of ACCESS discards the transfer
    slv_stuck = 1'b1;
    raise(0, 1'b0, 8'h37, 8'h00);
    wait_accept(0);
    @(posedge PCLK); #3;
    check("pre-reset PENABLE", 32'(PENABLE), 1);
    RSTN = 1'b0;
    #1;
    check("async reset PSEL", 32'(PSEL), 0);
    check("async reset PENABLE", 32'(PENABLE), 0);
    check("async reset busy", 32'(busy), 0);
    @(negedge PCLK);
    slv_stuck = 1'b0;
    RSTN = 1'b1;
    raise(0, 1'b0, 8'h37, 8'h00); expect_rsp(0, 8'hAA, 1'b0, 1'b0);
    raise(1, 1'b0, 8'hCA, 8'h00); expect_rsp(1, 8'h55, 1'b0, 1'b0);
    #1;
    check("post-reset req0_ready", 32'(req0_ready), 1);
    check("post-reset req1_ready", 32'(req1_ready), 0);
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    check("post-reset SETUP PSEL", 32'(PSEL), 1);
    check("post-reset SETUP PENABLE", 32'(PENABLE), 0);
    @(negedge PCLK);
    wait_accept(1);
    wait_quiet();

    check("q0 empty at end", 32'(q0.size()), 0);
    check("q1 empty at end", 32'(q1.size()), 0);
    repeat (2) @(negedge PCLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
